// File: rtl/cmprs_in_fifo.sv
// Dual-clock input FIFO: 64-bit words in on wclk, 16-bit words out on rclk, tracked in 32-byte chunks.
// Define CMPRS_IN_FIFO_ERRFLAGS_EN to implement the sticky ovf/udf flags; otherwise they read 0.
`timescale 1ns/1ps
module cmprs_in_fifo (
    input  logic        rst,
    input  logic        wclk,
    input  logic        rclk,
    input  logic        rst_fifo,
    input  logic        we,
    input  logic [63:0] wdata,
    input  logic        wlast,
    output logic [7:0]  wfree,
    input  logic        ren,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        rempty,
    output logic [7:0]  ravail,
    output logic        eof,
    output logic        ovf,
    output logic        udf
);

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [63:0]  mem [512];
    logic [127:0] last_flags;

    logic [7:0]  wptr, wgray, rgray_s1, rgray_s2, wptr_nxt, wused, wfree_raw;
    logic [1:0]  wsub;
    logic        req_tgl, ack_s1, ack_s2, wblocked, w_acc, w_done;

    logic [7:0]  rptr, rgray, wgray_s1, wgray_s2, rptr_nxt, rdiff;
    logic [3:0]  rsub;
    logic        req_s1, req_s2, req_s3, ack_tgl, flush_hit, r_acc, r_done;
    logic [10:0] rd_addr_p0;
    logic        vld_p0;
    logic [63:0] word_p1;
    logic [1:0]  lane_p1;
    logic        vld_p1, eof_p1;

    // A flush request is a toggle; writes stay blocked until the read side echoes it back.
    assign wblocked  = req_tgl ^ ack_s2;
    assign wused     = wptr - gray2bin(rgray_s2);
    assign wfree_raw = 8'd128 - wused;
    assign wfree     = wblocked ? 8'd0 : wfree_raw;
    assign w_acc     = we & ~rst_fifo & ~((wfree == 8'd0) & (wsub == 2'd0));
    assign w_done    = w_acc & (wlast | (wsub == 2'd3));
    assign wptr_nxt  = wptr + {7'd0, w_done};

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            wgray      <= '0;
            wsub       <= '0;
            last_flags <= '0;
            req_tgl    <= 1'b0;
            rgray_s1   <= '0;
            rgray_s2   <= '0;
            ack_s1     <= 1'b0;
            ack_s2     <= 1'b0;
        end else begin
            rgray_s1 <= rgray;
            rgray_s2 <= rgray_s1;
            ack_s1   <= ack_tgl;
            ack_s2   <= ack_s1;
            if (rst_fifo) begin
                wptr       <= '0;
                wgray      <= '0;
                wsub       <= '0;
                last_flags <= '0;
                if (!wblocked) req_tgl <= ~req_tgl;
            end else begin
                if (w_acc) wsub <= w_done ? 2'd0 : wsub + 2'd1;
                if (w_done) last_flags[wptr[6:0]] <= wlast;
                wptr  <= wptr_nxt;
                wgray <= bin2gray(wptr_nxt);
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (w_acc) mem[{wptr[6:0], wsub}] <= wdata;
    end

    // The flush cycle itself reports empty so stale synced pointers are never read from.
    assign flush_hit = req_s2 ^ req_s3;
    assign rdiff     = gray2bin(wgray_s2) - rptr;
    assign ravail    = flush_hit ? 8'd0 : rdiff;
    assign rempty    = (ravail == 8'd0);
    assign r_acc     = ren & ~rempty;
    assign r_done    = r_acc & (rsub == 4'd15);
    assign rptr_nxt  = rptr + {7'd0, r_done};

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rptr       <= '0;
            rgray      <= '0;
            rsub       <= '0;
            wgray_s1   <= '0;
            wgray_s2   <= '0;
            req_s1     <= 1'b0;
            req_s2     <= 1'b0;
            req_s3     <= 1'b0;
            ack_tgl    <= 1'b0;
            rd_addr_p0 <= '0;
            vld_p0     <= 1'b0;
            word_p1    <= '0;
            lane_p1    <= '0;
            vld_p1     <= 1'b0;
            eof_p1     <= 1'b0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            eof        <= 1'b0;
        end else begin
            wgray_s1 <= wgray;
            wgray_s2 <= wgray_s1;
            req_s1   <= req_tgl;
            req_s2   <= req_s1;
            req_s3   <= req_s2;
            ack_tgl  <= req_s3;
            if (flush_hit) begin
                rptr   <= '0;
                rgray  <= '0;
                rsub   <= '0;
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                eof_p1 <= 1'b0;
                rvalid <= 1'b0;
                eof    <= 1'b0;
            end else begin
                if (r_acc) rsub <= rsub + 4'd1;
                rptr  <= rptr_nxt;
                rgray <= bin2gray(rptr_nxt);
                // stage p0: capture accepted read address
                rd_addr_p0 <= {rptr[6:0], rsub};
                vld_p0     <= r_acc;
                // stage p1: registered memory read
                word_p1 <= mem[rd_addr_p0[10:2]];
                lane_p1 <= rd_addr_p0[1:0];
                vld_p1  <= vld_p0;
                eof_p1  <= vld_p0 & (rd_addr_p0[3:0] == 4'hf) & last_flags[rd_addr_p0[10:4]];
                // stage p2: lane select to output
                rvalid <= vld_p1;
                eof    <= eof_p1;
                if (vld_p1) rdata <= word_p1[{lane_p1, 4'd0} +: 16];
            end
        end
    end

`ifdef CMPRS_IN_FIFO_ERRFLAGS_EN
    logic ovf_r, udf_r;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst)                ovf_r <= 1'b0;
        else if (rst_fifo)      ovf_r <= 1'b0;
        else if (we && !w_acc)  ovf_r <= 1'b1;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst)                udf_r <= 1'b0;
        else if (flush_hit)     udf_r <= 1'b0;
        else if (ren && rempty) udf_r <= 1'b1;
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: doc/cmprs_in_fifo.md
CMPRS_IN_FIFO -- requirements
Module: cmprs_in_fifo

Interface
REQ-001 The block SHALL have the following ports:
- rst  in  1  reset, asynchronous, active-high.
- wclk  in  1  write clock (memory-read side).
- rclk  in  1  read clock (decompressor side).
- rst_fifo  in  1  wclk domain; flush FIFO, zero pointers and counts.
- we  in  1  write one 64-bit word.
- wdata  in  64  write data.
- wlast  in  1  qualified by we; last word of a frame.
- wfree  out  8  free 32-byte chunks, 0..128, wclk domain.
- ren  in  1  read one 16-bit word.
- rdata  out  16  read data.
- rvalid  out  1  rdata valid.
- rempty  out  1  no complete chunk available.
- ravail  out  8  complete 32-byte chunks available, 0..128, rclk domain.
- eof  out  1  single rclk pulse; last word of a frame was read.
- ovf  out  1  sticky overflow, wclk domain.
- udf  out  1  sticky underflow, rclk domain.

Function
REQ-002 Storage SHALL be 4096 bytes, organized as 512x64 on the write side, 2048x16 on the read side, i.e. 128 chunks of 32 bytes.
REQ-003 Word order: each 64-bit word SHALL be read as four 16-bit words, bits [15:0] first and [63:48] last.
REQ-004 Write pointer waddr[8:0] SHALL increment on each accepted we.
REQ-005 A chunk SHALL complete on a write when waddr[1:0]==3.
REQ-006 On we&wlast with waddr[1:0]!=3, the block SHALL advance waddr to the next multiple of 4, complete the chunk, and leave the pad words undefined.
REQ-007 A per-chunk last-flag array (128 bits) SHALL be written in wclk at chunk completion, set to 1 on wlast and 0 otherwise.
REQ-008 Read pointer raddr[10:0] SHALL increment on each accepted ren, defined as ren & !rempty.
REQ-009 A chunk SHALL be consumed when an accepted ren has raddr[3:0]==15.
REQ-010 Chunk pointers (8 bits each, 7 bits plus wrap bit) SHALL cross domains as Gray code through two-flop synchronizers; no other multi-bit signal crosses domains.
REQ-011 ravail SHALL equal synced write chunk pointer minus read chunk pointer, mod 256.
REQ-012 rempty SHALL equal (ravail==0).
REQ-013 Write-to-read latency SHALL be at most 4 rclk cycles from chunk completion to the ravail increment.
REQ-014 wfree SHALL equal 128 minus (write chunk pointer minus synced read chunk pointer).
REQ-015 wfree SHALL be conservative: it never exceeds the true free space.
REQ-016 A write with we while wfree==0 and waddr[1:0]==0 SHALL be dropped and set ovf.
REQ-017 Read latency: accepted ren at rclk edge N SHALL present rdata and rvalid=1 after edge N+2. This is a registered memory output.
REQ-018 rvalid SHALL be 0 in any cycle that does not correspond to an accepted ren two cycles earlier.
REQ-019 A ren while rempty SHALL be ignored and set udf.
REQ-020 The raddr and ravail decrement SHALL happen in the cycle of the accepted ren.
REQ-021 eof SHALL pulse for one rclk cycle, aligned with rvalid, for the final word of a chunk whose last flag is 1.
REQ-022 Simultaneous chunk completion and chunk consumption SHALL net to an unchanged count, with no lost update.
REQ-023 Pointer wrap at 128 chunks SHALL be transparent.
REQ-024 A full FIFO SHALL give ravail==128 and wfree==0.

Reset
REQ-025 rst SHALL asynchronously clear all registers in both domains.
REQ-026 After rst the outputs SHALL be: wfree=128, rdata=0, rvalid=0, rempty=1, ravail=0, eof=0, ovf=0, udf=0.
REQ-027 rst_fifo SHALL synchronously clear the wclk-side pointers, the last flags, and ovf.
REQ-028 rst_fifo SHALL be passed to rclk through a two-flop synchronizer.
REQ-029 The rclk side SHALL clear raddr, its chunk pointer, rvalid, eof and udf on the synchronized pulse.
REQ-030 Writes SHALL be blocked, with wfree forced to 0, until the rclk-side clear is acknowledged back in wclk, at most 6 cycles of the slower clock.
REQ-031 rst_fifo asserted mid-chunk SHALL discard the partial chunk.

Configuration
REQ-032 Macro CMPRS_IN_FIFO_ERRFLAGS_EN SHALL control the error flags.
- Defined: ovf and udf are implemented per REQ-016 and REQ-019.
- Undefined: ovf and udf are tied to 0, and drop/ignore behaviour is unchanged.

Verification
REQ-033 Reset: rst pulse -> wfree=128, ravail=0, rempty=1, rvalid=0 immediately.
REQ-034 Basic transfer and ordering: write 8 words 0x0003_0002_0001_0000 + 0x4_0004_0004_0004*i, then read 32 -> rdata sequence 0x0000,0x0001,0x0002,0x0003,0x0004,...; ravail goes 2 to 0; eof never.
REQ-035 Padded last chunk: write 6 words with wlast on the 6th -> ravail=2, waddr=8; reading 32 words -> single eof with the 32nd rvalid.
REQ-036 Full and overflow: write 512 words without reading -> wfree=0, ravail=128; the 513th write is dropped and ovf=1 (errflags build); rdata after read matches the first word.
REQ-037 Underflow: ren with rempty=1 -> no rvalid, raddr unchanged, udf=1.
REQ-038 Concurrency and flush: wclk=100 MHz, rclk=150 MHz, random ren, 10000 words streamed with pointer wrap -> bit-exact data.
- Then rst_fifo mid-chunk -> ravail=0, wfree=128 within 6 cycles.
